// File: rtl/spw_link_sequencer.sv
// spw_link_sequencer
//   Brings a SpaceWire codec link up and keeps it there. Enables the codec,
//   waits up to TIMEOUT cycles for the Run state, backs off for 8 cycles on a
//   timeout or link drop, then retries. After MAX_RETRY retries it parks in
//   FAILED until software clears EN.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   address, chipselect,
//   write_n, writedata  Avalon-MM slave (zero wait states)
//   readdata            combinational read data for 'address'
//   link_running        codec is in Run state
//   link_error          codec single-cycle error pulse
//   spw_cfg             codec config {link_disable, autostart, link_start}
//   irq                 level interrupt on FAILED
//
// Register map
//   0 CTRL      [0] EN, [1] AUTOSTART, [2] IRQ_EN
//   1 STATUS    [2:0] state, [3] link_running, [4] FAILED (write 1 clears),
//               [11:8] retry count
//   2 TIMEOUT   [TIMEOUT_W-1:0]
//   3 MAX_RETRY [3:0]
//
// Build option
//   SPW_SEQ_IRQ_EN  defined: IRQ_EN bit exists and irq = IRQ_EN & FAILED.
//                   undefined: irq tied low, CTRL[2] reads 0.

module spw_link_sequencer #(
  parameter int TIMEOUT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        link_running,
  input  logic        link_error,
  output logic [2:0]  spw_cfg,
  output logic        irq
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_WAIT_RUN = 3'd2,
    S_RUNNING  = 3'd3,
    S_BACKOFF  = 3'd4,
    S_FAILED   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 en_q, en_d;
  logic                 auto_q, auto_d;
  logic                 failed_q, failed_d;
  logic [3:0]           retry_q, retry_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic [3:0]           max_retry_q, max_retry_d;
  logic [2:0]           bo_cnt_q, bo_cnt_d;
  logic [2:0]           spw_cfg_q, spw_cfg_d;
  logic                 irq_en;
  logic                 wr;
  logic                 unused_wd;

  assign unused_wd = ^writedata;
  assign wr        = chipselect & ~write_n;

`ifdef SPW_SEQ_IRQ_EN
  logic irq_en_q, irq_en_d;
  assign irq_en = irq_en_q;
  assign irq    = irq_en_q & failed_q;
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    auto_d      = auto_q;
    failed_d    = failed_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    timeout_d   = timeout_q;
    max_retry_d = max_retry_q;
    bo_cnt_d    = bo_cnt_q;
`ifdef SPW_SEQ_IRQ_EN
    irq_en_d    = irq_en_q;
`endif

    // Register writes land next cycle; the FSM below only looks at *_q, so a
    // CTRL write racing a transition sees the old value.
    if (wr) begin
      case (address)
        2'd0: begin
          en_d   = writedata[0];
          auto_d = writedata[1];
`ifdef SPW_SEQ_IRQ_EN
          irq_en_d = writedata[2];
`endif
        end
        2'd1: if (writedata[4]) failed_d = 1'b0;
        2'd2: timeout_d   = writedata[TIMEOUT_W-1:0];
        default: max_retry_d = writedata[3:0];
      endcase
    end

    if (state_q != S_IDLE && !en_q) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (en_q) begin
          state_d = S_START;
          retry_d = 4'd0;
        end
        S_START: begin
          timer_d = timeout_q;
          state_d = S_WAIT_RUN;
        end
        S_WAIT_RUN: begin
          if (link_running) begin
            state_d = S_RUNNING;
            retry_d = 4'd0;
          end else if (timer_q == '0) begin
            state_d  = S_BACKOFF;
            bo_cnt_d = 3'd0;
          end else begin
            timer_d = timer_q - TIMEOUT_W'(1);
          end
        end
        S_RUNNING: if (link_error || !link_running) begin
          state_d  = S_BACKOFF;
          bo_cnt_d = 3'd0;
        end
        S_BACKOFF: begin
          if (bo_cnt_q == 3'd7) begin
            if (retry_q == max_retry_q) begin
              state_d = S_FAILED;
            end else begin
              retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
              state_d = S_START;
            end
          end else begin
            bo_cnt_d = bo_cnt_q + 3'd1;
          end
        end
        S_FAILED: ;
        default: state_d = S_IDLE;
      endcase
    end

    // Entering FAILED outranks a same-cycle software clear.
    if (state_d == S_FAILED && state_q != S_FAILED) failed_d = 1'b1;

    // Output follows the current state one cycle later; link_start and
    // link_disable are mutually exclusive by construction.
    case (state_q)
      S_START, S_WAIT_RUN, S_RUNNING: spw_cfg_d = {1'b0, auto_q, 1'b1};
      default:                        spw_cfg_d = 3'b100;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      en_q        <= 1'b0;
      auto_q      <= 1'b0;
      failed_q    <= 1'b0;
      retry_q     <= 4'd0;
      timer_q     <= '0;
      timeout_q   <= '1;
      max_retry_q <= 4'd3;
      bo_cnt_q    <= 3'd0;
      spw_cfg_q   <= 3'b100;
`ifdef SPW_SEQ_IRQ_EN
      irq_en_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      auto_q      <= auto_d;
      failed_q    <= failed_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      timeout_q   <= timeout_d;
      max_retry_q <= max_retry_d;
      bo_cnt_q    <= bo_cnt_d;
      spw_cfg_q   <= spw_cfg_d;
`ifdef SPW_SEQ_IRQ_EN
      irq_en_q    <= irq_en_d;
`endif
    end
  end

  assign spw_cfg = spw_cfg_q;

  always_comb begin
    case (address)
      2'd0:    readdata = {29'd0, irq_en, auto_q, en_q};
      2'd1:    readdata = {20'd0, retry_q, 3'd0, failed_q, link_running, state_q};
      2'd2:    readdata = 32'(timeout_q);
      default: readdata = {28'd0, max_retry_q};
    endcase
  end

endmodule

// File: doc/spw_link_sequencer.md
SPW_LINK_SEQUENCER -- requirements
Module: spw_link_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 16, width of the link-up timeout register and timer.
REQ-002 SHALL have port clk  input  1  sole clock, all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port address  input  2  Avalon-MM slave register select.
REQ-005 SHALL have port chipselect  input  1  slave select.
REQ-006 SHALL have port write_n  input  1  active-low write strobe.
REQ-007 SHALL have port writedata  input  32  write data.
REQ-008 SHALL have port readdata  output  32  read data, combinational from address, unused bits 0.
REQ-009 SHALL have port link_running  input  1  codec reports link in Run state.
REQ-010 SHALL have port link_error  input  1  codec single-cycle link error pulse.
REQ-011 SHALL have port spw_cfg  output  3  codec config: bit0 link_start, bit1 autostart, bit2 link_disable.
REQ-012 SHALL have port irq  output  1  level interrupt.

Function
REQ-013 SHALL decode a write when chipselect=1 and write_n=0; zero wait states; reads have zero latency.
REQ-014 Addr 0 CTRL R/W: bit0 EN, bit1 AUTOSTART, bit2 IRQ_EN; other bits read 0.
REQ-015 Addr 1 STATUS RO: [2:0] state code, bit3 link_running, bit4 FAILED sticky, [11:8] retry count; write with writedata[4]=1 clears FAILED.
REQ-016 Addr 2 TIMEOUT R/W, [TIMEOUT_W-1:0]; addr 3 MAX_RETRY R/W, [3:0].
REQ-017 FSM states/codes: IDLE=0, START=1, WAIT_RUN=2, RUNNING=3, BACKOFF=4, FAILED=5.
REQ-018 IDLE: spw_cfg=100; EN=1 -> START, retry count cleared.
REQ-019 START: one cycle; timer loaded with TIMEOUT; spw_cfg={0,AUTOSTART,1}; -> WAIT_RUN.
REQ-020 WAIT_RUN: spw_cfg={0,AUTOSTART,1}; link_running=1 -> RUNNING; else timer=0 -> BACKOFF; else timer decrements by 1.
REQ-021 RUNNING: spw_cfg={0,AUTOSTART,1}; retry count cleared on entry; link_error=1 or link_running=0 -> BACKOFF.
REQ-022 BACKOFF: spw_cfg=100 for exactly 8 cycles; then retry count = MAX_RETRY -> FAILED, else retry count +1 and -> START.
REQ-023 FAILED: spw_cfg=100; FAILED sticky set on entry; EN=0 -> IDLE.
REQ-024 EN=0 in any non-IDLE state SHALL force IDLE next cycle, priority over all other transitions.
REQ-025 link_running and link_error in the same WAIT_RUN cycle: link_running wins (-> RUNNING); link_error ignored outside RUNNING.
REQ-026 TIMEOUT=0: WAIT_RUN lasts one cycle then BACKOFF unless link_running already 1.
REQ-027 MAX_RETRY=0: first BACKOFF completion -> FAILED (one attempt total); retry count saturates at 15.
REQ-028 CTRL write coinciding with a transition: FSM uses pre-write register value that cycle.
REQ-029 spw_cfg SHALL be registered (one cycle after state entry); link_start and link_disable never both 1.
REQ-030 Clearing FAILED while in FAILED SHALL not change state.

Reset
REQ-031 reset=1: state IDLE, CTRL=0, FAILED=0, retry count=0, timer=0, TIMEOUT all ones, MAX_RETRY=3.
REQ-032 Reset outputs: spw_cfg=100, irq=0; reset mid-operation aborts within one cycle.

Configuration
REQ-033 Macro SPW_SEQ_IRQ_EN defined: irq = CTRL.IRQ_EN & FAILED; CTRL bit2 writable.
REQ-034 Macro SPW_SEQ_IRQ_EN undefined: irq tied 0, CTRL bit2 reads 0, no IRQ flop.

Verification
REQ-035 Reset, read all addrs -> CTRL=0, STATUS=0, TIMEOUT=0xFFFF, MAX_RETRY=3, spw_cfg=100.
REQ-036 TIMEOUT=10, EN=1, link_running rises 5 cycles after START -> RUNNING, spw_cfg=001, STATUS[2:0]=3.
REQ-037 TIMEOUT=4, MAX_RETRY=2, link_running held 0 -> 3 START attempts, each 8-cycle BACKOFF, then FAILED, STATUS bit4=1, irq=1 (IRQ_EN=1, macro on).
REQ-038 In RUNNING, link_error pulse -> BACKOFF next cycle, spw_cfg=100 for 8 cycles, then START.
REQ-039 In WAIT_RUN write CTRL=0 -> IDLE next cycle, spw_cfg=100; write STATUS bit4=1 in FAILED -> FAILED cleared, irq=0.
REQ-040 Assert reset in BACKOFF cycle 3 -> IDLE, all registers at reset values next cycle.
